// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings, FSM state type and alignment check for the MEM stage
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Size code 11 is handled as a word, so it shares the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication/byte enables, load extraction/extension, misalignment
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_word_i,
  output logic [31:0] store_word_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = read_word_i[{offset_i, 3'b000} +: 8];
  assign sel_half = offset_i[1] ? read_word_i[31:16] : read_word_i[15:0];

  always_comb begin
    store_word_o = store_data_i;
    byte_en_o    = 4'b1111;
    load_data_o  = read_word_i;
    case (size_i)
      SZ_BYTE: begin
        store_word_o = {4{store_data_i[7:0]}};
        byte_en_o    = 4'b0001 << offset_i;
        load_data_o  = unsigned_i ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        store_word_o = {2{store_data_i[15:0]}};
        byte_en_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        load_data_o  = unsigned_i ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: ;
    endcase
  end

  assign misaligned_o = is_misaligned(size_i, offset_i);

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: byte-lane word memory, wait-state stall FSM, MEM/WB latch
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        inValid,
  input  logic [31:0] inMemAddress,
  input  logic [31:0] inStoreData,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [1:0]  inSize,
  input  logic        inUnsigned,
  input  logic [1:0]  inMemtoReg,
  input  logic        inRegWrite,
  input  logic [4:0]  inWriteReg,
  output logic        stall,
  output logic [31:0] outLoadData,
  output logic [31:0] outAluLatch,
  output logic [1:0]  outMemtoReg,
  output logic        outRegWrite,
  output logic [4:0]  outWriteReg,
  output logic        outValid,
  output logic        outMisaligned
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  mem_state_e        state_q;
  logic [2:0]        cnt_q;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       store_word;
  logic [3:0]        byte_en;
  logic [31:0]       load_ext;
  logic              misaligned;
  logic              mem_op, access, mis_access, is_load, done, issue;

  assign word_idx   = inMemAddress[ADDR_W+1:2];
  assign mem_op     = inMemRead | inMemWrite;
  assign access     = inValid & mem_op & ~misaligned;
  assign mis_access = inValid & mem_op & misaligned;
  assign is_load    = access & inMemRead & ~inMemWrite;
  assign done       = (state_q == ST_BUSY) && (cnt_q == 3'd0);
  assign issue      = (state_q == ST_IDLE) && access;
  assign stall      = access & ~done;

  mem_lane_align u_align (
    .size_i       (inSize),
    .offset_i     (inMemAddress[1:0]),
    .unsigned_i   (inUnsigned),
    .store_data_i (inStoreData),
    .read_word_i  (rdata_q),
    .store_word_o (store_word),
    .byte_en_o    (byte_en),
    .load_data_o  (load_ext),
    .misaligned_o (misaligned)
  );

  // The array is never reset; the access is sampled only on the issue edge.
  always_ff @(posedge clk) begin
    if (issue && rst_n) begin
      if (inMemWrite) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= store_word[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[word_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            state_q <= ST_BUSY;
            cnt_q   <= WAIT_INIT;
          end
        end
        ST_BUSY: begin
          if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
          else if (enable)   state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [31:0] load_q, load_d, alu_q, alu_d;
  logic [1:0]  memtoreg_q, memtoreg_d;
  logic [4:0]  writereg_q, writereg_d;
  logic        regwrite_q, regwrite_d, valid_q, valid_d, mis_q, mis_d;

  always_comb begin
    load_d     = load_q;
    alu_d      = alu_q;
    memtoreg_d = memtoreg_q;
    regwrite_d = regwrite_q;
    writereg_d = writereg_q;
    valid_d    = valid_q;
    mis_d      = mis_q;
    if (enable) begin
      if (stall) begin
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
      end else begin
        load_d     = is_load ? load_ext : 32'd0;
        alu_d      = inMemAddress;
        memtoreg_d = inMemtoReg;
        regwrite_d = inRegWrite & ~mis_access;
        writereg_d = inWriteReg;
        valid_d    = inValid;
        mis_d      = mis_access;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q     <= 32'd0;
      alu_q      <= 32'd0;
      memtoreg_q <= 2'd0;
      regwrite_q <= 1'b0;
      writereg_q <= 5'd0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      load_q     <= load_d;
      alu_q      <= alu_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      writereg_q <= writereg_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
    end
  end

  assign outLoadData   = load_q;
  assign outAluLatch   = alu_q;
  assign outMemtoReg   = memtoreg_q;
  assign outRegWrite   = regwrite_q;
  assign outWriteReg   = writereg_q;
  assign outValid      = valid_q;
  assign outMisaligned = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized model-checked bench; instance g has WAIT_CYCLES=g
module tb_mem_access_stage;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2], en [2], v [2], rd [2], wr [2], uns [2], rw [2];
  logic [31:0] addr [2], sd [2];
  logic [1:0]  sz [2], m2r [2];
  logic [4:0]  wreg [2];
  logic        st [2], o_rw [2], o_v [2], o_mis [2];
  logic [31:0] o_ld [2], o_alu [2];
  logic [1:0]  o_m2r [2];
  logic [4:0]  o_wreg [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_stage #(.ADDR_W(AW), .WAIT_CYCLES(g)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .enable        (en[g]),
      .inValid       (v[g]),
      .inMemAddress  (addr[g]),
      .inStoreData   (sd[g]),
      .inMemRead     (rd[g]),
      .inMemWrite    (wr[g]),
      .inSize        (sz[g]),
      .inUnsigned    (uns[g]),
      .inMemtoReg    (m2r[g]),
      .inRegWrite    (rw[g]),
      .inWriteReg    (wreg[g]),
      .stall         (st[g]),
      .outLoadData   (o_ld[g]),
      .outAluLatch   (o_alu[g]),
      .outMemtoReg   (o_m2r[g]),
      .outRegWrite   (o_rw[g]),
      .outWriteReg   (o_wreg[g]),
      .outValid      (o_v[g]),
      .outMisaligned (o_mis[g])
    );
  end

  typedef struct packed {
    logic [31:0] ld;
    logic [31:0] alu;
    logic [1:0]  m2r;
    logic [4:0]  wreg;
    logic        rw;
    logic        v;
    logic        mis;
  } lat_t;

  lat_t       exp_l [2];
  logic       exp_st [2];
  int         stall_seen [2];
  logic [7:0] mb [2][4096];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    stall_seen[0] = 0;
    stall_seen[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        stall_seen[d] += int'(st[d]);
        chk($sformatf("stall[%0d]", d), 32'(st[d]), 32'(exp_st[d]));
        chk($sformatf("load[%0d]", d), o_ld[d], exp_l[d].ld);
        chk($sformatf("alu[%0d]", d), o_alu[d], exp_l[d].alu);
        chk($sformatf("m2r[%0d]", d), 32'(o_m2r[d]), 32'(exp_l[d].m2r));
        chk($sformatf("wreg[%0d]", d), 32'(o_wreg[d]), 32'(exp_l[d].wreg));
        chk($sformatf("regwr[%0d]", d), 32'(o_rw[d]), 32'(exp_l[d].rw));
        chk($sformatf("valid[%0d]", d), 32'(o_v[d]), 32'(exp_l[d].v));
        chk($sformatf("mis[%0d]", d), 32'(o_mis[d]), 32'(exp_l[d].mis));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the latch has captured.
  task automatic issue(input int d, input logic valid, input logic r, input logic w,
                       input logic [1:0] size, input logic un, input logic [31:0] a,
                       input logic [31:0] data, input logic rwin, input int hold,
                       output int stalls);
    logic        mis, memop, acc;
    logic [31:0] val;
    logic [7:0]  b;
    logic [15:0] h;
    int          n, ba, base;
    v[d] = valid; rd[d] = r; wr[d] = w; sz[d] = size; uns[d] = un;
    addr[d] = a; sd[d] = data; rw[d] = rwin;
    m2r[d] = 2'($urandom); wreg[d] = 5'($urandom);
    memop = r | w;
    mis   = (size == 2'b00) ? 1'b0 : (size == 2'b01) ? a[0] : (a[1:0] != 2'b00);
    acc   = valid & memop & ~mis;
    n     = acc ? d + 1 : 0;
    ba    = int'(a[11:0]);
    val   = 32'd0;
    if (acc && w) begin
      mb[d][ba] = data[7:0];
      if (size == 2'b01 || size[1]) mb[d][ba+1] = data[15:8];
      if (size[1]) begin
        mb[d][ba+2] = data[23:16];
        mb[d][ba+3] = data[31:24];
      end
    end else if (acc && r) begin
      if (size == 2'b00) begin
        b   = mb[d][ba];
        val = un ? {24'd0, b} : 32'($signed(b));
      end else if (size == 2'b01) begin
        h   = {mb[d][ba+1], mb[d][ba]};
        val = un ? {16'd0, h} : 32'($signed(h));
      end else begin
        val = {mb[d][ba+3], mb[d][ba+2], mb[d][ba+1], mb[d][ba]};
      end
    end
    base      = stall_seen[d];
    exp_st[d] = (n > 0);
    en[d]     = (n > 0) ? 1'b1 : (hold == 0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      exp_l[d].v  = 1'b0;
      exp_l[d].rw = 1'b0;
      exp_st[d]   = (k < n);
    end
    en[d] = (hold == 0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    en[d] = 1'b1;
    @(posedge clk); #1;
    exp_l[d].ld   = (acc && r && !w) ? val : 32'd0;
    exp_l[d].alu  = a;
    exp_l[d].m2r  = m2r[d];
    exp_l[d].wreg = wreg[d];
    exp_l[d].rw   = rwin & ~(valid & memop & mis);
    exp_l[d].v    = valid;
    exp_l[d].mis  = valid & memop & mis;
    en[d] = 1'b0;
    v[d]  = 1'b0;
    stalls = stall_seen[d] - base;
  endtask

  int s;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; en[d] = 1'b0; v[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
      uns[d] = 1'b0; rw[d] = 1'b0; addr[d] = '0; sd[d] = '0; sz[d] = '0;
      m2r[d] = '0; wreg[d] = '0; exp_l[d] = '0; exp_st[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_load", o_ld[d], 32'd0);
      chk("reset_valid", 32'(o_v[d]), 32'd0);
      chk("reset_stall", 32'(st[d]), 32'd0);
    end
    v[1] = 1'b1; rd[1] = 1'b1; sz[1] = 2'b10; addr[1] = 32'h20; exp_st[1] = 1'b1;
    #2;
    chk("reset_stall_comb", 32'(st[1]), 32'd1);
    v[1] = 1'b0; rd[1] = 1'b0; exp_st[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    issue(1, 1, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 0, s);
    chk("sw_stall_cycles", s, 2);
    issue(1, 1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0, s);
    chk("lw_stall_cycles", s, 2);
    chk("lw_data", o_ld[1], 32'hDEADBEEF);
    issue(1, 1, 0, 1, 2'b00, 0, 32'h13, 32'h80, 0, 0, s);
    issue(1, 1, 1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 0, s);
    chk("lb_data", o_ld[1], 32'hFFFFFF80);
    issue(1, 1, 1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 0, s);
    chk("lbu_data", o_ld[1], 32'h00000080);
    issue(1, 1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0, s);
    chk("lw_after_sb", o_ld[1], 32'h80ADBEEF);
    issue(1, 1, 0, 1, 2'b01, 0, 32'h12, 32'h1234, 0, 0, s);
    issue(1, 1, 1, 0, 2'b01, 0, 32'h12, 32'h0, 1, 0, s);
    chk("lh_data", o_ld[1], 32'h00001234);
    issue(1, 1, 1, 0, 2'b01, 0, 32'h11, 32'h0, 1, 0, s);
    chk("lh_mis_flag", 32'(o_mis[1]), 32'd1);
    chk("lh_mis_regwr", 32'(o_rw[1]), 32'd0);
    chk("lh_mis_stall", s, 0);
    issue(1, 1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 3, s);
    chk("lw_hold_data", o_ld[1], 32'h1234BEEF);

    v[1] = 1'b1; rd[1] = 1'b1; wr[1] = 1'b0; sz[1] = 2'b10; addr[1] = 32'h10;
    en[1] = 1'b1; exp_st[1] = 1'b1;
    @(posedge clk); #1;
    exp_l[1].v = 1'b0; exp_l[1].rw = 1'b0;
    rst_n[1] = 1'b0; v[1] = 1'b0; exp_l[1] = '0; exp_st[1] = 1'b0;
    #1;
    chk("rst_busy_alu", o_alu[1], 32'd0);
    chk("rst_busy_load", o_ld[1], 32'd0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1; en[1] = 1'b0;
    chk("rst_busy_stall", 32'(st[1]), 32'd0);
    issue(1, 1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0, s);
    chk("lw_after_reset", o_ld[1], 32'h1234BEEF);

    issue(0, 1, 0, 0, 2'b10, 0, 32'h1234_5678, 32'h0, 1, 0, s);
    chk("add_stall", s, 0);
    chk("add_alu", o_alu[0], 32'h1234_5678);
    issue(0, 1, 0, 1, 2'b10, 0, 32'h40, 32'hCAFE_F00D, 1, 0, s);
    issue(0, 1, 1, 0, 2'b10, 0, 32'h40, 32'h0, 1, 0, s);
    chk("w0_lw_stall", s, 1);
    chk("w0_lw_data", o_ld[0], 32'hCAFEF00D);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        issue(d, 1, 0, 1, 2'b10, 0, 32'(i * 4), $urandom, 0, 0, s);
      for (int i = 0; i < 80; i++) begin
        int          k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        issue(d, $urandom_range(0, 9) != 0, (k >= 3 && k <= 5) || k == 9, k >= 6,
              2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, 1'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, s);
      end
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
